// File: rtl/bus_reader_pkg.sv
// rtl/bus_reader_pkg.sv - shared widths and FSM encoding for the bus reader
package bus_reader_pkg;
  localparam int BR_DATAWIDTH = 16;
  localparam int BR_SRCW      = 2;
  localparam int BR_NSRC      = 4;

  typedef enum logic [1:0] {
    BR_IDLE   = 2'd0,
    BR_DRIVE  = 2'd1,
    BR_SAMPLE = 2'd2,
    BR_TURN   = 2'd3
  } br_state_e;
endpackage

// File: rtl/bus_reader_sync_fifo2.sv
// rtl/bus_reader_sync_fifo2.sv - 2-entry synchronous FIFO with registered head
module sync_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] head_q, tail_q;
  logic [1:0]       count_q;
  logic             pop_eff, push_eff;

  assign pop_eff   = pop && (count_q != 2'd0);
  assign push_eff  = push && ((count_q != 2'd2) || pop_eff);
  assign head_data = head_q;
  assign full      = (count_q == 2'd2);
  assign empty     = (count_q == 2'd0);

  // Head only changes when a new word reaches it, so it holds its last value once drained.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
    end else begin
      case (count_q)
        2'd0: begin
          if (push_eff) begin
            head_q  <= push_data;
            count_q <= 2'd1;
          end
        end
        2'd1: begin
          if (push_eff && pop_eff) begin
            head_q <= push_data;
          end else if (push_eff) begin
            tail_q  <= push_data;
            count_q <= 2'd2;
          end else if (pop_eff) begin
            count_q <= 2'd0;
          end
        end
        default: begin
          if (pop_eff) begin
            head_q <= tail_q;
            if (push_eff) tail_q <= push_data;
            else          count_q <= 2'd1;
          end
        end
      endcase
    end
  end
endmodule

// File: rtl/bus_reader.sv
// rtl/bus_reader.sv - sequences tristate bus drivers and captures one word per request
module bus_reader
  import bus_reader_pkg::*;
#(
  parameter int DATAWIDTH = BR_DATAWIDTH,
  parameter int NSRC      = BR_NSRC,
  parameter int SRCW      = BR_SRCW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  input  logic [SRCW-1:0]      req_src,
  output logic                 req_ready,
  output logic [NSRC-1:0]      drv_en,
  input  logic [DATAWIDTH-1:0] bus_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATAWIDTH-1:0] out_data,
  output logic [SRCW-1:0]      out_src,
  output logic                 out_err,
  output logic                 busy
);
  localparam int FW = DATAWIDTH + SRCW + 1;

  br_state_e       state, next_state;
  logic [SRCW-1:0] cur_src;
  logic [NSRC-1:0] src_onehot;
  logic            src_ok;
  logic            fifo_push, fifo_full, fifo_empty;
  logic [FW-1:0]   push_data, head_data;

  // An out-of-range index matches no bit, so its transfer runs with every driver off.
  always_comb begin
    src_onehot = '0;
    for (int i = 0; i < NSRC; i++) src_onehot[i] = (cur_src == SRCW'(i));
  end
  assign src_ok = |src_onehot;

  always_comb begin
    next_state = state;
    req_ready  = 1'b0;
    drv_en     = '0;
    fifo_push  = 1'b0;
    case (state)
      BR_IDLE: begin
        req_ready = !fifo_full && !reset;
        if (req_valid && req_ready) next_state = BR_DRIVE;
      end
      BR_DRIVE: begin
        drv_en     = src_onehot;
        next_state = BR_SAMPLE;
      end
      BR_SAMPLE: begin
        drv_en     = src_onehot;
        fifo_push  = 1'b1;
        next_state = BR_TURN;
      end
      BR_TURN:  next_state = BR_IDLE;
      default:  next_state = BR_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= BR_IDLE;
      cur_src <= '0;
    end else begin
      state <= next_state;
      if (state == BR_IDLE && req_valid && req_ready) cur_src <= req_src;
    end
  end

  assign push_data = {(src_ok ? bus_in : {DATAWIDTH{1'b0}}), cur_src, !src_ok};

  sync_fifo2 #(.WIDTH(FW)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (out_ready),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid                  = !fifo_empty;
  assign {out_data, out_src, out_err} = head_data;
  assign busy                       = (state != BR_IDLE);
endmodule

// File: tb/tb_bus_reader.sv
// tb/tb_bus_reader.sv - randomized self-checking bench for bus_reader
module tb_bus_reader;
  localparam int DW   = 16;
  localparam int NSRC = 3;
  localparam int SRCW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic [SRCW-1:0] req_src = '0;
  logic            req_ready;
  logic [NSRC-1:0] drv_en;
  logic [DW-1:0]   bus_in;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [SRCW-1:0] out_src;
  logic            out_err;
  logic            busy;

  typedef struct packed {
    logic [DW-1:0]   data;
    logic [SRCW-1:0] src;
    logic            err;
  } exp_t;

  logic [DW-1:0]   src_word [0:3];
  exp_t            exp_q[$];
  int              checks = 0;
  int              failures = 0;
  int              delivered = 0;
  bit              rand_ready = 0;
  logic [NSRC-1:0] prev_drv = '0;

  bus_reader #(.DATAWIDTH(DW), .NSRC(NSRC), .SRCW(SRCW)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_src(req_src),
    .req_ready(req_ready), .drv_en(drv_en), .bus_in(bus_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_src(out_src), .out_err(out_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Resolved bus: the enabled source's word, or a distinct junk pattern when nobody drives.
  always_comb begin
    bus_in = 16'hBEEF;
    for (int i = 0; i < NSRC; i++) if (drv_en[i]) bus_in = src_word[i];
  end

  // Reference model: every accepted request yields exactly one word, delivered in order.
  always @(negedge clk) begin
    exp_t e;
    exp_t h;
    checks++;
    if ($countones(drv_en) > 1) begin
      failures++; $display("FAIL drv_onehot drv_en=%b required at most one bit set", drv_en);
    end
    checks++;
    if (prev_drv != '0 && drv_en != '0 && drv_en != prev_drv) begin
      failures++; $display("FAIL drv_turnaround prev=%b now=%b required a dead cycle", prev_drv, drv_en);
    end
    checks++;
    if (!busy && drv_en != '0) begin
      failures++; $display("FAIL drv_idle drv_en=%b required 0 while idle", drv_en);
    end
    prev_drv = drv_en;
    if (reset) begin
      exp_q.delete();
    end else begin
      if (req_valid && req_ready) begin
        e.src  = req_src;
        e.err  = (int'(req_src) >= NSRC);
        e.data = e.err ? 16'h0000 : src_word[req_src];
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL sb_spurious got data=%h src=%0d required no word", out_data, out_src);
        end else begin
          h = exp_q.pop_front();
          if ({out_data, out_src, out_err} !== h) begin
            failures++;
            $display("FAIL sb_word got data=%h src=%0d err=%b required data=%h src=%0d err=%b",
                     out_data, out_src, out_err, h.data, h.src, h.err);
          end
          delivered++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [SRCW-1:0] src);
    int n = 0;
    req_valid = 1'b1; req_src = src;
    @(negedge clk);
    while (!req_ready && n < 60) begin
      @(posedge clk); #1;
      if (rand_ready) out_ready = 1'($urandom);
      @(negedge clk);
      n++;
    end
    checks++;
    if (!req_ready) begin
      failures++; $display("FAIL issue_timeout req_ready=%b required 1 within 60 cycles", req_ready);
    end
    step();
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || busy) && n < 200) begin
      step(); n++;
    end
    checks++;
    if (exp_q.size() != 0 || busy) begin
      failures++; $display("FAIL drain_timeout pending=%0d busy=%b required 0/0", exp_q.size(), busy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if ({drv_en, req_ready, out_valid, out_data, out_src, out_err, busy} !== '0) begin
      failures++;
      $display("FAIL reset_state drv=%b rdy=%b ov=%b od=%h os=%0d oe=%b busy=%b required all 0",
               drv_en, req_ready, out_valid, out_data, out_src, out_err, busy);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (drv_en !== '0 || out_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        failures++;
        $display("FAIL idle_state drv=%b ov=%b rdy=%b busy=%b required 000/0/1/0",
                 drv_en, out_valid, req_ready, busy);
      end
      step();
    end
  endtask

  task automatic test_single();
    src_word[2] = 16'hA5C3;
    out_ready = 1'b1;
    req_valid = 1'b1; req_src = 2'd2;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL single_accept req_ready=%b required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (drv_en !== ((c < 3) ? 3'b100 : 3'b000)) begin
        failures++; $display("FAIL single_drv cycle=%0d drv_en=%b", c, drv_en);
      end
      if (c == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hA5C3 || out_src !== 2'd2 || out_err !== 1'b0) begin
          failures++;
          $display("FAIL single_out ov=%b data=%h src=%0d err=%b required 1/a5c3/2/0",
                   out_valid, out_data, out_src, out_err);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [NSRC-1:0] exp_drv [1:7];
    exp_drv = '{3'b001, 3'b001, 3'b000, 3'b000, 3'b010, 3'b010, 3'b000};
    src_word[0] = 16'h1111; src_word[1] = 16'h2222;
    out_ready = 1'b1;
    req_valid = 1'b1; req_src = 2'd0;
    @(negedge clk);
    step();
    req_src = 2'd1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checks++;
      if (drv_en !== exp_drv[c] || out_valid !== (c == 3 || c == 7)) begin
        failures++;
        $display("FAIL b2b_timing cycle=%0d drv_en=%b ov=%b required %b/%b",
                 c, drv_en, out_valid, exp_drv[c], (c == 3 || c == 7));
      end
      if (c == 3 || c == 7) begin
        checks++;
        if (out_data !== ((c == 3) ? 16'h1111 : 16'h2222)) begin
          failures++; $display("FAIL b2b_data cycle=%0d got=%h", c, out_data);
        end
      end
      if (c == 4) begin
        checks++;
        if (req_ready !== 1'b1) begin
          failures++; $display("FAIL b2b_accept req_ready=%b required 1", req_ready);
        end
      end
      step();
      if (c == 4) req_valid = 1'b0;
    end
  endtask

  task automatic test_backpressure();
    int base;
    logic [SRCW-1:0] s [3];
    int n = 0;
    for (int i = 0; i < 3; i++) begin
      s[i] = SRCW'($urandom_range(0, NSRC - 1));
      src_word[i] = 16'($urandom);
    end
    base = delivered;
    out_ready = 1'b0;
    issue(s[0]);
    issue(s[1]);
    req_valid = 1'b1; req_src = s[2];
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
        failures++; $display("FAIL bp_hold cycle=%0d req_ready=%b required 0", c, req_ready);
      end
      step();
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || out_data !== src_word[s[0]]) begin
      failures++;
      $display("FAIL bp_head ov=%b busy=%b data=%h required 1/0/%h",
               out_valid, busy, out_data, src_word[s[0]]);
    end
    step();
    out_ready = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 10) begin
      step(); @(negedge clk); n++;
    end
    checks++;
    if (!req_ready) begin
      failures++; $display("FAIL bp_release req_ready=%b required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    drain();
    checks++;
    if (delivered - base !== 3) begin
      failures++; $display("FAIL bp_count delivered=%0d required 3", delivered - base);
    end
  endtask

  task automatic test_out_of_range();
    out_ready = 1'b1;
    req_valid = 1'b1; req_src = 2'd3;
    @(negedge clk);
    checks++;
    if (req_ready !== 1'b1) begin
      failures++; $display("FAIL oor_accept req_ready=%b required 1", req_ready);
    end
    step();
    req_valid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      checks++;
      if (drv_en !== '0) begin
        failures++; $display("FAIL oor_drv cycle=%0d drv_en=%b required 000", c, drv_en);
      end
      if (c == 3) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h0000 || out_err !== 1'b1 || out_src !== 2'd3) begin
          failures++;
          $display("FAIL oor_out ov=%b data=%h err=%b src=%0d required 1/0000/1/3",
                   out_valid, out_data, out_err, out_src);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    int base = delivered;
    src_word[1] = 16'($urandom);
    out_ready = 1'b1;
    issue(2'd1);
    step();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (drv_en !== 3'b010) begin
      failures++; $display("FAIL rmid_sample drv_en=%b required 010", drv_en);
    end
    step();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (drv_en !== '0 || out_valid !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rmid_after cycle=%0d drv=%b ov=%b busy=%b required 000/0/0", c, drv_en, out_valid, busy);
      end
      step();
    end
    checks++;
    if (delivered !== base) begin
      failures++; $display("FAIL rmid_lost delivered=%0d required %0d", delivered - base, 0);
    end
  endtask

  task automatic test_random();
    int base = delivered;
    int gap;
    rand_ready = 1;
    for (int i = 0; i < 30; i++) begin
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        out_ready = 1'($urandom);
        step();
      end
      if (!busy) for (int k = 0; k < 4; k++) src_word[k] = 16'($urandom);
      issue(SRCW'($urandom_range(0, 3)));
    end
    rand_ready = 0;
    drain();
    checks++;
    if (delivered - base !== 30) begin
      failures++; $display("FAIL rand_count delivered=%0d required 30", delivered - base);
    end
  endtask

  initial begin
    for (int k = 0; k < 4; k++) src_word[k] = 16'h0000;
    test_reset();
    test_single();
    test_back_to_back();
    drain();
    test_backpressure();
    test_out_of_range();
    drain();
    test_reset_mid();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL final_pending pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_reader.md
Name: bus_reader

Overview:
- Receive end of the CPU shared 16-bit tristate data bus.
- Sequences the per-source drive enables that feed the tribuf16 instances, one source at a time, with a guaranteed dead cycle between owners.
- Samples the bus once the selected driver has settled and delivers the word, tagged with its source index, to a consumer through a 2-entry valid/ready output buffer.
- Sits between the datapath control unit (issues read requests) and any bus consumer (register file write port, memory address latch).

Parameters:
- DATAWIDTH, default `DATAWIDTH (16): bus and data width.
- NSRC, default 4: number of bus drivers; each gets one drv_en bit.
- SRCW, default 2: source index width; NSRC <= 2**SRCW.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  read request present.
- req_src  in  SRCW  index of the driver to enable.
- req_ready  out  1  request accepted when req_valid && req_ready.
- drv_en  out  NSRC  one-hot-or-zero enables to tribuf16 en inputs.
- bus_in  in  DATAWIDTH  resolved shared bus value.
- out_valid  out  1  head of output buffer valid.
- out_ready  in  1  consumer accepts head when out_valid && out_ready.
- out_data  out  DATAWIDTH  captured bus word.
- out_src  out  SRCW  source index of out_data.
- out_err  out  1  head entry came from an out-of-range source.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (synchronous, active-high; takes effect at the clock edge where reset=1):
  - drv_en=0, req_ready=0, out_valid=0, out_data=0, out_src=0, out_err=0, busy=0.
  - FSM goes to IDLE and the buffer is emptied. This applies mid-transfer too: any in-flight request is discarded.
- FSM states: IDLE, DRIVE, SAMPLE, TURN.
- IDLE:
  - req_ready = (buffer count < 2); drv_en=0.
  - On accept, latch req_src into cur_src and go to DRIVE.
- DRIVE: drv_en[cur_src]=1 (settle cycle), then go to SAMPLE.
- SAMPLE:
  - drv_en[cur_src]=1.
  - At the end of the cycle, push {bus_in, cur_src, err} into the buffer, then go to TURN.
- TURN: drv_en=0 (bus turnaround dead cycle), then go to IDLE.
- Timing: accept in cycle 0 → drv_en high in cycles 1–2 → out_valid=1 in cycle 3 if the buffer was empty. Maximum throughput is 1 word per 4 cycles.
- Invariants:
  - At most one drv_en bit is high in any cycle.
  - drv_en is never high in IDLE or TURN.
  - drv_en is never high in two consecutive transfers without an intervening TURN.
- Out-of-range cur_src (>= NSRC):
  - Request is accepted and sequenced normally, but drv_en stays 0.
  - Pushed entry has data=0 and err=1.
- Output buffer (2-entry FIFO):
  - Head is registered onto out_data/out_src/out_err.
  - Push and pop in the same cycle are both honoured and count is unchanged.
  - Pop when empty is ignored.
  - Push cannot overflow, because req_ready is gated on count < 2 at accept time and there is only one transfer in flight.
- Outputs when out_valid=0: out_data/out_src/out_err hold their last value. Consumers ignore them.
- busy = (state != IDLE).
- req_valid in a non-IDLE state is held off (req_ready=0). The requester must keep req_valid and req_src stable until accepted.

Decomposition:
- Shared defines (defines.v): DATAWIDTH (already present), SRCW, NSRC default, and state encodings BR_IDLE/BR_DRIVE/BR_SAMPLE/BR_TURN (2 bits).
- Sub-module sync_fifo2: 2-entry synchronous FIFO, parameterised width, with push/pop/full/empty/count. Width = DATAWIDTH+SRCW+1.
- The FSM and one-hot drv_en decode stay in bus_reader.

Test Plan:
- Reset, then idle: drv_en=0, out_valid=0, req_ready=1, busy=0 for 5 cycles.
- Single read: src=2, bus model drives 16'hA5C3 while drv_en[2]=1 → drv_en=4'b0100 in cycles 1–2 and 0 in cycle 3; out_valid=1, out_data=16'hA5C3, out_src=2 in cycle 3.
- Back-to-back reads: src 0 (16'h1111) then src 1 (16'h2222) with out_ready=1 → one zero-drv_en cycle between owners; two outputs 4 cycles apart, in order.
- Backpressure: out_ready=0, issue 3 requests → two entries buffered, req_ready=0 with the third held. Raise out_ready → third accepted, all 3 delivered in order, none lost.
- Out-of-range: NSRC=3, req_src=3 → drv_en stays 0 throughout; out_data=0, out_err=1, out_src=3.
- Reset mid-transfer: assert reset during SAMPLE → next cycle drv_en=0, out_valid=0, state IDLE, no word delivered.
